// File: rtl/sisc_ir_sequencer.sv
// Instruction-stream engine: writable program store played back onto IR, one word per HOLD-cycle slot.
// Optional SISC_SEQ_ICOUNT_EN adds a saturating completed-slot counter on port icount.
module sisc_ir_sequencer #(
  parameter int unsigned     IR_W    = 32,
  parameter int unsigned     ADDR_W  = 4,
  parameter int unsigned     HOLD    = 5,
  parameter int unsigned     OP_W    = 4,
  parameter logic [OP_W-1:0] HALT_OP = OP_W'('hF)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [IR_W-1:0]   wr_data,
  input  logic              start,
  input  logic              pause,
  output logic [IR_W-1:0]   IR,
  output logic              ir_valid,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              halted,
  output logic              overrun
`ifdef SISC_SEQ_ICOUNT_EN
  ,
  output logic [15:0]       icount
`endif
);

  localparam int unsigned       DEPTH     = 2 ** ADDR_W;
  localparam int unsigned       HOLD_W    = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD - 1);
  localparam logic [ADDR_W-1:0] PC_LAST   = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ISSUE  = 2'd1,
    S_HALTED = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [IR_W-1:0]     ir_q, ir_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic                overrun_q, overrun_d;
  logic                ir_valid_q, ir_valid_d;
  logic                busy_q, busy_d;
  logic                halted_q, halted_d;
  logic [IR_W-1:0]     mem_q [DEPTH];
`ifdef SISC_SEQ_ICOUNT_EN
  logic [15:0]         icount_q, icount_d;
`endif

  // Program store: not reset; the fetch reads the pre-edge contents, so a same-edge write yields the old word.
  always_ff @(posedge CLK) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  // Next-state and slot sequencing
  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    pc_d      = pc_q;
    hold_d    = hold_q;
    overrun_d = overrun_q;
`ifdef SISC_SEQ_ICOUNT_EN
    icount_d  = icount_q;
`endif
    case (state_q)
      S_IDLE, S_HALTED: begin
        if (start) begin
          state_d   = S_ISSUE;
          ir_d      = mem_q[ADDR_W'(0)];
          pc_d      = '0;
          hold_d    = '0;
          overrun_d = 1'b0;
`ifdef SISC_SEQ_ICOUNT_EN
          icount_d  = '0;
`endif
        end
      end
      S_ISSUE: begin
        if (!pause) begin
          if (hold_q < HOLD_LAST) begin
            hold_d = hold_q + HOLD_W'(1);
          end else begin
`ifdef SISC_SEQ_ICOUNT_EN
            if (icount_q != 16'hFFFF) begin
              icount_d = icount_q + 16'd1;
            end
`endif
            if (ir_q[IR_W-1 -: OP_W] == HALT_OP) begin
              state_d = S_HALTED;
            end else if (pc_q == PC_LAST) begin
              state_d   = S_HALTED;
              overrun_d = 1'b1;
            end else begin
              pc_d   = pc_q + ADDR_W'(1);
              ir_d   = mem_q[pc_q + ADDR_W'(1)];
              hold_d = '0;
            end
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    ir_valid_d = (state_d != S_IDLE);
    busy_d     = (state_d == S_ISSUE);
    halted_d   = (state_d == S_HALTED);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= S_IDLE;
      ir_q       <= '0;
      pc_q       <= '0;
      hold_q     <= '0;
      overrun_q  <= 1'b0;
      ir_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      halted_q   <= 1'b0;
`ifdef SISC_SEQ_ICOUNT_EN
      icount_q   <= '0;
`endif
    end else begin
      state_q    <= state_d;
      ir_q       <= ir_d;
      pc_q       <= pc_d;
      hold_q     <= hold_d;
      overrun_q  <= overrun_d;
      ir_valid_q <= ir_valid_d;
      busy_q     <= busy_d;
      halted_q   <= halted_d;
`ifdef SISC_SEQ_ICOUNT_EN
      icount_q   <= icount_d;
`endif
    end
  end

  assign IR       = ir_q;
  assign ir_valid = ir_valid_q;
  assign pc       = pc_q;
  assign busy     = busy_q;
  assign halted   = halted_q;
  assign overrun  = overrun_q;
`ifdef SISC_SEQ_ICOUNT_EN
  assign icount   = icount_q;
`endif

endmodule
